fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register feeding the main decoder.
//  Holds the PC, selects PC+4 or the resolved branch/jump target, drives the
//  instruction-memory address, and registers InstrD/PCD/PCPlus4D for decode.
//  Supports load-use stalls, flush on redirect, and a retired-fetch counter.
// PARAMETERS
//  RESET_VECTOR  32'hBFC0_0000  PC value loaded on reset
//  NOP_INSTR     32'h0000_0013  bubble inserted on flush (addi x0,x0,0)
//  CNT_W         32             width of FetchCount
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  StallF      in   1      hold PC (hazard unit)
//  StallD      in   1      hold IF/ID register
//  FlushD      in   1      replace IF/ID contents with bubble
//  PCsrc       in   1      1 = take PCTarget next, 0 = PC+4
//  PCTarget    in   32     branch/JAL/JALR target from execute
//  InstrRD     in   32     instruction-memory read data (combinational on PCF)
//  PCF         out  32     current fetch PC = instruction-memory address
//  InstrD      out  32     registered instruction; InstrD[6:0] is decoder op
//  PCD         out  32     PC of InstrD
//  PCPlus4D    out  32     PCD+4, used for JAL/JALR link writeback
//  ValidD      out  1      InstrD is a real fetched instruction (0 = bubble)
//  MisalignErr out  1      sticky: a redirect target had PCTarget[1:0]!=0
//  FetchCount  out  CNT_W  count of instructions loaded into IF/ID
// BEHAVIOUR
//  Reset (async assert, sync release): PCF=RESET_VECTOR, InstrD=NOP_INSTR,
//   PCD=0, PCPlus4D=0, ValidD=0, MisalignErr=0, FetchCount=0.
//  PC update each rising edge, priority order:
//   1. PCsrc=1        -> PCF <= {PCTarget[31:2],2'b00} (redirect beats StallF)
//   2. StallF=1       -> PCF holds
//   3. otherwise      -> PCF <= PCF+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
//  Misalign: PCsrc=1 with PCTarget[1:0]!=0 sets MisalignErr; cleared only by rst.
//  IF/ID update each rising edge, priority order:
//   1. FlushD=1 -> InstrD<=NOP_INSTR, ValidD<=0, PCD/PCPlus4D<=0 (beats StallD)
//   2. StallD=1 -> all IF/ID outputs hold
//   3. otherwise-> InstrD<=InstrRD, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1
//  Latency: instruction at PCF appears on InstrD one cycle later.
//  FetchCount increments by 1 on every edge taking case 3 of IF/ID; wraps at
//   2^CNT_W-1 -> 0; never increments on flush or stall.
//  StallF=1 with StallD=0 and no flush: IF/ID reloads the same PCF (duplicate
//   fetch legal; hazard unit never requests this, no special handling).
//  PCsrc=1 and FlushD=0 in same cycle: IF/ID loads the wrong-path instruction
//   normally; hazard unit is responsible for flushing it.
//  rst asserted mid-stall or mid-redirect: all state returns to reset values
//   immediately; first fetch after release is RESET_VECTOR.
//  No combinational path from any input to any output except none; all outputs
//   are registered.
// TESTING
//  1. rst pulse, then 3 free cycles, InstrRD=PC-based pattern -> PCF=BFC00000,
//     BFC00004, BFC00008; InstrD lags 1 cycle; ValidD=1 from 2nd edge; FetchCount=3.
//  2. PCsrc=1, PCTarget=BFC00040, FlushD=1 same cycle -> next PCF=BFC00040,
//     InstrD=00000013, ValidD=0, FetchCount unchanged.
//  3. StallF=1,StallD=1 for 2 cycles at PCF=BFC00010 -> PCF, InstrD, PCD and
//     FetchCount all frozen; resume -> PCF=BFC00014.
//  4. StallF=1 and PCsrc=1, PCTarget=BFC00102 -> PCF=BFC00100, MisalignErr=1,
//     stays 1 through later normal fetches until rst.
//  5. Force PCF=FFFFFFFC via redirect, free run -> PCF wraps to 00000000,
//     PCPlus4D for that fetch =00000000.
//  6. Assert rst asynchronously mid-cycle during stall -> outputs reset before
//     next clock edge; FetchCount=0, ValidD=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register that feeds the decoder.
// Latency: the instruction at PCF appears on InstrD one clock later.
// Backpressure: StallF holds the PC and StallD holds IF/ID. FlushD inserts a bubble.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   StallF, StallD, FlushD    hazard-unit controls
//   PCsrc, PCTarget           redirect request and target from execute
//   InstrRD                   instruction-memory read data (combinational on PCF)
//   PCF                       fetch PC, which is also the instruction-memory address
//   InstrD, PCD, PCPlus4D     registered instruction, its PC, and its PC+4
//   ValidD                    InstrD holds a real instruction (0 = bubble)
//   MisalignErr               sticky flag: a redirect target was not word aligned
//   FetchCount                number of instructions loaded into IF/ID
module fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
   parameter int          CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             PCsrc,
   input  logic [31:0]      PCTarget,
   input  logic [31:0]      InstrRD,
   output logic [31:0]      PCF,
   output logic [31:0]      InstrD,
   output logic [31:0]      PCD,
   output logic [31:0]      PCPlus4D,
   output logic             ValidD,
   output logic             MisalignErr,
   output logic [CNT_W-1:0] FetchCount
);

   logic [31:0] pc_plus4;
   logic        target_misaligned;

   // The adder wraps mod 2^32, so a fetch at FFFFFFFC links to 0.
   assign pc_plus4          = PCF + 32'd4;
   assign target_misaligned = (PCTarget[1:0] != 2'b00);

   // PC register. A redirect must win over a stall, otherwise a taken branch
   // that coincides with a load-use stall would be lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PCF         <= RESET_VECTOR;
         MisalignErr <= 1'b0;
      end else begin
         if (PCsrc) begin
            PCF <= {PCTarget[31:2], 2'b00};
            if (target_misaligned)
               MisalignErr <= 1'b1;
         end else if (!StallF) begin
            PCF <= pc_plus4;
         end
      end
   end

   // IF/ID register. A flush wins over a stall, so a squashed slot never
   // survives as a held instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         InstrD     <= NOP_INSTR;
         PCD        <= 32'd0;
         PCPlus4D   <= 32'd0;
         ValidD     <= 1'b0;
         FetchCount <= '0;
      end else if (FlushD) begin
         InstrD   <= NOP_INSTR;
         PCD      <= 32'd0;
         PCPlus4D <= 32'd0;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         InstrD     <= InstrRD;
         PCD        <= PCF;
         PCPlus4D   <= pc_plus4;
         ValidD     <= 1'b1;
         FetchCount <= FetchCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam logic [31:0] RV  = 32'hBFC0_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallf, stalld, flushd, pcsrc;
   logic [31:0] pctarget;
   logic [31:0] instrrd;
   logic [31:0] pcf, instrd, pcd, pcplus4d;
   logic        validd, misalignerr;
   logic [31:0] fetchcount;

   int checks = 0;
   int errors = 0;

   // Reference state, advanced one clock at a time from the fetch rules.
   logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
   logic        m_vld, m_mis;

   always #5 clk = ~clk;

   // Instruction memory: a fixed scramble of the address.
   function automatic logic [31:0] imem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   assign instrrd = imem(pcf);

   fetch_stage dut (
      .clk(clk), .rst(rst),
      .StallF(stallf), .StallD(stalld), .FlushD(flushd),
      .PCsrc(pcsrc), .PCTarget(pctarget), .InstrRD(instrrd),
      .PCF(pcf), .InstrD(instrd), .PCD(pcd), .PCPlus4D(pcplus4d),
      .ValidD(validd), .MisalignErr(misalignerr), .FetchCount(fetchcount)
   );

   task automatic model_reset();
      m_pc = RV; m_instr = NOP; m_pcd = 0; m_pc4 = 0;
      m_vld = 0; m_mis = 0; m_cnt = 0;
   endtask

   task automatic idle_inputs();
      stallf = 0; stalld = 0; flushd = 0; pcsrc = 0; pctarget = 0;
   endtask

   // One clock edge. The model advances from the inputs held across the edge,
   // and the outputs are sampled 1 ns later.
   task automatic step();
      logic [31:0] n_pc;
      n_pc = pcsrc ? {pctarget[31:2], 2'b00} : (stallf ? m_pc : m_pc + 32'd4);
      if (pcsrc && (pctarget[1:0] != 2'b00)) m_mis = 1'b1;
      if (flushd) begin
         m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_vld = 0;
      end else if (!stalld) begin
         m_instr = imem(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 32'd4;
         m_vld = 1; m_cnt = m_cnt + 1;
      end
      m_pc = n_pc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs(); model_reset();
      #2;
      checks++; if (pcf !== RV) begin errors++; $display("FAIL reset_pcf got %h want %h", pcf, RV); end
      checks++; if (instrd !== NOP) begin errors++; $display("FAIL reset_instrd got %h want %h", instrd, NOP); end
      checks++; if (pcd !== 0 || pcplus4d !== 0) begin errors++; $display("FAIL reset_pcd got %h/%h want 0/0", pcd, pcplus4d); end
      checks++; if (validd !== 0 || misalignerr !== 0) begin errors++; $display("FAIL reset_flags got %b%b want 00", validd, misalignerr); end
      checks++; if (fetchcount !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", fetchcount); end
      @(negedge clk); rst = 0;
      #1;
   endtask

   task automatic test_free_run();
      logic [31:0] exp_pc;
      exp_pc = RV;
      for (int i = 0; i < 3; i++) begin
         checks++; if (pcf !== exp_pc) begin errors++; $display("FAIL free_pcf%0d got %h want %h", i, pcf, exp_pc); end
         step();
         checks++; if (instrd !== imem(exp_pc) || pcd !== exp_pc || validd !== 1'b1)
            begin errors++; $display("FAIL free_ifid%0d got %h/%h/%b want %h/%h/1", i, instrd, pcd, validd, imem(exp_pc), exp_pc); end
         exp_pc = exp_pc + 4;
      end
      checks++; if (fetchcount !== 3) begin errors++; $display("FAIL free_count got %0d want 3", fetchcount); end
   endtask

   task automatic test_redirect_flush();
      logic [31:0] cnt0;
      cnt0 = fetchcount;
      pcsrc = 1; pctarget = 32'hBFC0_0040; flushd = 1;
      step();
      idle_inputs();
      checks++; if (pcf !== 32'hBFC0_0040) begin errors++; $display("FAIL redir_pcf got %h want bfc00040", pcf); end
      checks++; if (instrd !== NOP || validd !== 0 || pcd !== 0)
         begin errors++; $display("FAIL redir_bubble got %h/%b/%h want 00000013/0/0", instrd, validd, pcd); end
      checks++; if (fetchcount !== cnt0) begin errors++; $display("FAIL redir_count got %0d want %0d", fetchcount, cnt0); end
   endtask

   task automatic test_stall();
      logic [31:0] i0, p0, c0;
      pcsrc = 1; pctarget = 32'hBFC0_0010;
      step();
      idle_inputs();
      step();
      i0 = m_instr; p0 = m_pcd; c0 = m_cnt;
      stallf = 1; stalld = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (pcf !== 32'hBFC0_0014 || instrd !== i0 || pcd !== p0 || fetchcount !== c0)
            begin errors++; $display("FAIL stall%0d got %h/%h/%h/%0d want bfc00014/%h/%h/%0d", i, pcf, instrd, pcd, fetchcount, i0, p0, c0); end
      end
      idle_inputs();
      step();
      checks++; if (pcf !== 32'hBFC0_0018 || pcd !== 32'hBFC0_0014)
         begin errors++; $display("FAIL stall_resume got %h/%h want bfc00018/bfc00014", pcf, pcd); end
   endtask

   task automatic test_misalign();
      stallf = 1; pcsrc = 1; pctarget = 32'hBFC0_0102;
      step();
      idle_inputs();
      checks++; if (pcf !== 32'hBFC0_0100 || misalignerr !== 1)
         begin errors++; $display("FAIL misalign got %h/%b want bfc00100/1", pcf, misalignerr); end
      for (int i = 0; i < 3; i++) step();
      checks++; if (misalignerr !== 1 || pcf !== 32'hBFC0_010C)
         begin errors++; $display("FAIL misalign_sticky got %b/%h want 1/bfc0010c", misalignerr, pcf); end
   endtask

   task automatic test_wrap();
      pcsrc = 1; pctarget = 32'hFFFF_FFFC;
      step();
      idle_inputs();
      step();
      checks++; if (pcf !== 32'h0 || pcd !== 32'hFFFF_FFFC || pcplus4d !== 32'h0)
         begin errors++; $display("FAIL wrap got %h/%h/%h want 00000000/fffffffc/00000000", pcf, pcd, pcplus4d); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         stallf = ($urandom_range(0, 3) == 0);
         stalld = ($urandom_range(0, 3) == 0);
         flushd = ($urandom_range(0, 5) == 0);
         pcsrc  = ($urandom_range(0, 6) == 0);
         pctarget = $urandom;
         if ($urandom_range(0, 3) != 0) pctarget[1:0] = 2'b00;
         step();
         checks++;
         if (pcf !== m_pc || instrd !== m_instr || pcd !== m_pcd || pcplus4d !== m_pc4 ||
             validd !== m_vld || misalignerr !== m_mis || fetchcount !== m_cnt) begin
            errors++;
            $display("FAIL rand%0d got %h %h %h %h %b %b %0d want %h %h %h %h %b %b %0d", i,
                     pcf, instrd, pcd, pcplus4d, validd, misalignerr, fetchcount,
                     m_pc, m_instr, m_pcd, m_pc4, m_vld, m_mis, m_cnt);
         end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      step();
      stallf = 1; stalld = 1;
      step();
      #3 rst = 1;
      #1;
      model_reset();
      checks++; if (pcf !== RV || instrd !== NOP || validd !== 0 || fetchcount !== 0 || misalignerr !== 0)
         begin errors++; $display("FAIL async_rst got %h/%h/%b/%0d/%b want %h/%h/0/0/0", pcf, instrd, validd, fetchcount, misalignerr, RV, NOP); end
      #2 rst = 0;
      idle_inputs();
      step();
      checks++; if (pcd !== RV || pcf !== RV + 4 || fetchcount !== 1)
         begin errors++; $display("FAIL post_rst got %h/%h/%0d want %h/%h/1", pcd, pcf, fetchcount, RV, RV + 4); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_redirect_flush();
      test_stall();
      test_misalign();
      test_wrap();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
